// File: rtl/rv_mc_controller.sv
// rv_mc_controller: multi-cycle RV32 subset control unit (Moore FSM).
// FETCH, MEM_RD and MEM_WR stretch over MEM_LAT+1 cycles using a wait counter.
// Optional feature: define RV_MC_ILLEGAL_TRAP_EN to trap undefined opcodes in
// the TRAP state (illegal=1, held until reset); otherwise DECODE falls back
// to FETCH and illegal is tied low.
module rv_mc_controller #(
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       zero,
  input  logic       sign_bit,
  output logic       pc_we,
  output logic       old_pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic       mem_re,
  output logic       adr_sel,
  output logic [2:0] alu_op,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] result_sel,
  output logic [1:0] pc_sel,
  output logic [2:0] imm_sel,
  output logic [3:0] state_o,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_LUI     = 4'd12,
    S_TRAP    = 4'd15
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  // Operand / mux selects
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_SLT = 2'b10;
  localparam logic [1:0] RES_PC  = 2'b11;
  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_AOUT = 2'b01;
  localparam logic [1:0] PC_ALGN = 2'b10;

  localparam logic [CNT_W-1:0] LAT     = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_wait_state;
  logic             w_last;
  logic             w_is_r;
  logic             w_taken;
  logic [2:0]       w_alu_fn;

  // Raw (pre-reset-gating) enables
  logic w_pc_we, w_old_pc_we, w_ir_we, w_reg_we, w_mem_we, w_mem_re;

  // ALU function decoded from funct fields; SUB via f7 only for R-type.
  function automatic logic [2:0] f_alu(input logic [2:0] fn3,
                                       input logic [6:0] fn7,
                                       input logic       is_r);
    case (fn3)
      3'b000:  f_alu = (is_r && fn7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  f_alu = ALU_AND;
      3'b110:  f_alu = ALU_OR;
      3'b100:  f_alu = ALU_XOR;
      3'b010:  f_alu = ALU_SUB;
      default: f_alu = ALU_ADD;
    endcase
  endfunction

  assign w_is_r       = (op == OP_R);
  assign w_alu_fn     = f_alu(f3, f7, w_is_r);
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
  assign w_last       = (r_cnt == LAT);
  assign w_cnt_next   = (w_wait_state && !w_last) ? (r_cnt + CNT_ONE) : '0;

  // Branch condition evaluated on the ALU flags of rs1 - rs2.
  always_comb begin
    case (f3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = sign_bit;
      3'b101:  w_taken = ~sign_bit;
      default: w_taken = 1'b0;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_STORE:  imm_sel = 3'b001;
      OP_BRANCH: imm_sel = 3'b010;
      OP_JAL:    imm_sel = 3'b011;
      OP_LUI:    imm_sel = 3'b100;
      default:   imm_sel = 3'b000;
    endcase
  end

  // State and wait-counter register with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic.
  // NOTE: the default assigned first keeps every path driven, so no latch
  // is inferred even if a case arm forgets to assign.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:   if (w_last) w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next_state = S_MEM_ADR;
          OP_R:              w_next_state = S_EXEC_R;
          OP_I:              w_next_state = S_EXEC_I;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR;
          OP_LUI:            w_next_state = S_LUI;
`ifdef RV_MC_ILLEGAL_TRAP_EN
          default:           w_next_state = S_TRAP;
`else
          default:           w_next_state = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR: w_next_state = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (w_last) w_next_state = S_MEM_WB;
      S_MEM_WB:  w_next_state = S_FETCH;
      S_MEM_WR:  if (w_last) w_next_state = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:  w_next_state = S_ALU_WB;
      S_ALU_WB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_LUI:     w_next_state = S_FETCH;
`ifdef RV_MC_ILLEGAL_TRAP_EN
      S_TRAP:    w_next_state = S_TRAP;
`endif
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Per-state datapath controls; all enables and selects default to 0.
  always_comb begin
    w_pc_we     = 1'b0;
    w_old_pc_we = 1'b0;
    w_ir_we     = 1'b0;
    w_reg_we    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    adr_sel     = 1'b0;
    alu_op      = ALU_ADD;
    alu_a_sel   = A_PC;
    alu_b_sel   = B_RS2;
    result_sel  = RES_ALU;
    pc_sel      = PC_ALU;
    case (r_state)
      S_FETCH: begin
        w_mem_re    = 1'b1;
        alu_a_sel   = A_PC;
        alu_b_sel   = B_FOUR;
        w_ir_we     = w_last;
        w_old_pc_we = w_last;
        w_pc_we     = w_last;
      end
      S_DECODE: begin
        alu_a_sel = A_OLDPC;
        alu_b_sel = B_IMM;
      end
      S_MEM_ADR: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_IMM;
      end
      S_MEM_RD: begin
        w_mem_re = 1'b1;
        adr_sel  = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_we   = 1'b1;
        result_sel = RES_MEM;
      end
      S_MEM_WR: begin
        adr_sel  = 1'b1;
        w_mem_we = w_last;
      end
      S_EXEC_R: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_RS2;
        alu_op    = w_alu_fn;
      end
      S_EXEC_I: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_IMM;
        alu_op    = w_alu_fn;
      end
      S_ALU_WB: begin
        w_reg_we   = 1'b1;
        alu_a_sel  = A_RS1;
        alu_b_sel  = w_is_r ? B_RS2 : B_IMM;
        alu_op     = w_alu_fn;
        result_sel = (f3 == 3'b010) ? RES_SLT : RES_ALU;
      end
      S_BRANCH: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_RS2;
        alu_op    = ALU_SUB;
        pc_sel    = PC_AOUT;
        w_pc_we   = w_taken;
      end
      S_JAL: begin
        w_reg_we   = 1'b1;
        result_sel = RES_PC;
        w_pc_we    = 1'b1;
        pc_sel     = PC_AOUT;
      end
      S_JALR: begin
        alu_a_sel  = A_RS1;
        alu_b_sel  = B_IMM;
        pc_sel     = PC_ALGN;
        w_pc_we    = 1'b1;
        w_reg_we   = 1'b1;
        result_sel = RES_PC;
      end
      S_LUI: begin
        alu_a_sel = A_ZERO;
        alu_b_sel = B_IMM;
        w_reg_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are forced low during the reset cycle, including mid-wait.
  assign pc_we     = w_pc_we     & ~rst;
  assign old_pc_we = w_old_pc_we & ~rst;
  assign ir_we     = w_ir_we     & ~rst;
  assign reg_we    = w_reg_we    & ~rst;
  assign mem_we    = w_mem_we    & ~rst;
  assign mem_re    = w_mem_re    & ~rst;
  assign state_o   = r_state;

`ifdef RV_MC_ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_rv_mc_controller.sv
// Scoreboard bench for rv_mc_controller: the stimulus pushes the expected
// per-cycle control vector; a negedge monitor pops and compares it against
// the selected DUT instance (MEM_LAT = 0, 2, 3).
module tb_rv_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic [6:0] en;   // {pc_we, old_pc_we, ir_we, reg_we, mem_we, mem_re, adr_sel}
    logic [2:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [1:0] pcs;
    logic [2:0] imm;
  } out_t;

  localparam logic [6:0] E_PC  = 7'b1000000;
  localparam logic [6:0] E_OPC = 7'b0100000;
  localparam logic [6:0] E_IR  = 7'b0010000;
  localparam logic [6:0] E_REG = 7'b0001000;
  localparam logic [6:0] E_MWE = 7'b0000100;
  localparam logic [6:0] E_MRE = 7'b0000010;
  localparam logic [6:0] E_ADR = 7'b0000001;
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic [6:0] f7 = 7'd0;
  logic       zero = 1'b0;
  logic       sign_bit = 1'b0;

  logic [2:0] w_pc_we, w_old_pc_we, w_ir_we, w_reg_we, w_mem_we, w_mem_re;
  logic [2:0] w_adr_sel, w_ill;
  logic [2:0] w_alu [3];
  logic [1:0] w_a [3];
  logic [1:0] w_b [3];
  logic [1:0] w_res [3];
  logic [1:0] w_pcs [3];
  logic [2:0] w_imm [3];
  logic [3:0] w_st [3];
  out_t       act [3];

  int   sel = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  out_t exp_q [$];
  string nam_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    rv_mc_controller #(.MEM_LAT(LAT), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7),
      .zero(zero), .sign_bit(sign_bit),
      .pc_we(w_pc_we[g]), .old_pc_we(w_old_pc_we[g]), .ir_we(w_ir_we[g]),
      .reg_we(w_reg_we[g]), .mem_we(w_mem_we[g]), .mem_re(w_mem_re[g]),
      .adr_sel(w_adr_sel[g]), .alu_op(w_alu[g]), .alu_a_sel(w_a[g]),
      .alu_b_sel(w_b[g]), .result_sel(w_res[g]), .pc_sel(w_pcs[g]),
      .imm_sel(w_imm[g]), .state_o(w_st[g]), .illegal(w_ill[g])
    );
    assign act[g] = {w_st[g], w_ill[g],
                     w_pc_we[g], w_old_pc_we[g], w_ir_we[g], w_reg_we[g],
                     w_mem_we[g], w_mem_re[g], w_adr_sel[g],
                     w_alu[g], w_a[g], w_b[g], w_res[g], w_pcs[g], w_imm[g]};
  end

  function automatic out_t mk(input logic [3:0] st, input logic [6:0] en,
                              input logic [2:0] alu, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] res,
                              input logic [1:0] pcs, input logic [2:0] imm,
                              input logic ill = 1'b0);
    mk = {st, ill, en, alu, a, b, res, pcs, imm};
  endfunction

  task automatic check(input string nm, input out_t got, input out_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got st=%0d ill=%b en=%b alu=%b a=%b b=%b res=%b pc=%b imm=%b, want st=%0d ill=%b en=%b alu=%b a=%b b=%b res=%b pc=%b imm=%b",
               nm, got.st, got.ill, got.en, got.alu, got.a, got.b, got.res, got.pcs, got.imm,
               want.st, want.ill, want.en, want.alu, want.a, want.b, want.res, want.pcs, want.imm);
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string n;
      e = exp_q.pop_front();
      n = nam_q.pop_front();
      check(n, act[sel], e);
    end
  end

  task automatic step(input string nm, input out_t e);
    exp_q.push_back(e);
    nam_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Apply instruction fields, reset the DUTs and check the reset cycle.
  task automatic start(input int s, input logic [6:0] o, input logic [2:0] fn3,
                       input logic [6:0] fn7, input logic z, input logic sb,
                       input logic [2:0] imm);
    sel = s; op = o; f3 = fn3; f7 = fn7; zero = z; sign_bit = sb;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset", mk(4'd0, 7'd0, ADD, 2'b00, 2'b10, 2'b00, 2'b00, imm));
    rst = 1'b0;
  endtask

  task automatic fetch(input int n, input logic [2:0] imm);
    for (int i = 0; i < n - 1; i++)
      step("fetch_wait", mk(4'd0, E_MRE, ADD, 2'b00, 2'b10, 2'b00, 2'b00, imm));
    step("fetch_last", mk(4'd0, E_PC | E_OPC | E_IR | E_MRE, ADD, 2'b00, 2'b10,
                          2'b00, 2'b00, imm));
  endtask

  task automatic decode(input logic [2:0] imm);
    step("decode", mk(4'd1, 7'd0, ADD, 2'b01, 2'b01, 2'b00, 2'b00, imm));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // add, MEM_LAT=0: 0,1,6,8,0
    start(0, 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'b000);
    fetch(1, 3'b000);
    decode(3'b000);
    step("add_exec", mk(4'd6, 7'd0, ADD, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000));
    step("add_wb",   mk(4'd8, E_REG, ADD, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000));
    fetch(1, 3'b000);

    // sub (R-type, f7=0100000)
    start(0, 7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0, 3'b000);
    fetch(1, 3'b000);
    decode(3'b000);
    step("sub_exec", mk(4'd6, 7'd0, SUB, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000));
    step("sub_wb",   mk(4'd8, E_REG, SUB, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000));

    // addi with f7 bits set: f7 must not turn it into SUB
    start(0, 7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0, 3'b000);
    fetch(1, 3'b000);
    decode(3'b000);
    step("addi_exec", mk(4'd7, 7'd0, ADD, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000));
    step("addi_wb",   mk(4'd8, E_REG, ADD, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000));

    // slt, sign_bit=1
    start(0, 7'b0110011, 3'b010, 7'b0000000, 1'b0, 1'b1, 3'b000);
    fetch(1, 3'b000);
    decode(3'b000);
    step("slt_exec", mk(4'd6, 7'd0, SUB, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000));
    step("slt_wb",   mk(4'd8, E_REG, SUB, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

    // lw, MEM_LAT=2
    start(1, 7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 3'b000);
    fetch(3, 3'b000);
    decode(3'b000);
    step("lw_adr", mk(4'd2, 7'd0, ADD, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000));
    for (int i = 0; i < 3; i++)
      step("lw_rd", mk(4'd3, E_MRE | E_ADR, ADD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    step("lw_wb", mk(4'd4, E_REG, ADD, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000));
    step("lw_next", mk(4'd0, E_MRE, ADD, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000));

    // beq taken / not taken
    start(0, 7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0, 3'b010);
    fetch(1, 3'b010);
    decode(3'b010);
    step("beq_taken", mk(4'd9, E_PC, SUB, 2'b10, 2'b00, 2'b00, 2'b01, 3'b010));
    fetch(1, 3'b010);
    start(0, 7'b1100011, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'b010);
    fetch(1, 3'b010);
    decode(3'b010);
    step("beq_not", mk(4'd9, 7'd0, SUB, 2'b10, 2'b00, 2'b00, 2'b01, 3'b010));

    // blt taken on sign_bit, bge not taken on sign_bit
    start(0, 7'b1100011, 3'b100, 7'b0000000, 1'b0, 1'b1, 3'b010);
    fetch(1, 3'b010);
    decode(3'b010);
    step("blt_taken", mk(4'd9, E_PC, SUB, 2'b10, 2'b00, 2'b00, 2'b01, 3'b010));
    start(0, 7'b1100011, 3'b101, 7'b0000000, 1'b0, 1'b1, 3'b010);
    fetch(1, 3'b010);
    decode(3'b010);
    step("bge_not", mk(4'd9, 7'd0, SUB, 2'b10, 2'b00, 2'b00, 2'b01, 3'b010));

    // jal, jalr, lui
    start(0, 7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'b011);
    fetch(1, 3'b011);
    decode(3'b011);
    step("jal", mk(4'd10, E_PC | E_REG, ADD, 2'b00, 2'b00, 2'b11, 2'b01, 3'b011));
    start(0, 7'b1100111, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'b000);
    fetch(1, 3'b000);
    decode(3'b000);
    step("jalr", mk(4'd11, E_PC | E_REG, ADD, 2'b10, 2'b01, 2'b11, 2'b10, 3'b000));
    start(0, 7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'b100);
    fetch(1, 3'b100);
    decode(3'b100);
    step("lui", mk(4'd12, E_REG, ADD, 2'b11, 2'b01, 2'b00, 2'b00, 3'b100));

    // sw with MEM_LAT=3, reset on the second MEM_WR cycle
    start(2, 7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 3'b001);
    fetch(4, 3'b001);
    decode(3'b001);
    step("sw_adr", mk(4'd2, 7'd0, ADD, 2'b10, 2'b01, 2'b00, 2'b00, 3'b001));
    step("sw_wr1", mk(4'd5, E_ADR, ADD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001));
    rst = 1'b1;
    step("sw_wr2_rst", mk(4'd5, E_ADR, ADD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001));
    rst = 1'b0;
    fetch(4, 3'b001);

    // full sw with MEM_LAT=3: mem_we only on the last MEM_WR cycle
    start(2, 7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 3'b001);
    fetch(4, 3'b001);
    decode(3'b001);
    step("sw_adr", mk(4'd2, 7'd0, ADD, 2'b10, 2'b01, 2'b00, 2'b00, 3'b001));
    for (int i = 0; i < 3; i++)
      step("sw_wait", mk(4'd5, E_ADR, ADD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001));
    step("sw_last", mk(4'd5, E_ADR | E_MWE, ADD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001));
    step("sw_next", mk(4'd0, E_MRE, ADD, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001));

    // undefined opcode
    start(0, 7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'b000);
    fetch(1, 3'b000);
    decode(3'b000);
`ifdef RV_MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      step("trap_hold", mk(4'd15, 7'd0, ADD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
    start(0, 7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'b000);
`else
    fetch(1, 3'b000);
    decode(3'b000);
`endif

    // Drain: the monitor must have consumed every expectation.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
